// File: rtl/gf163_pkg.sv
// Shared field constants, FSM encoding and the B-163 reduction fold.
package gf163_pkg;

  localparam int M     = 163;
  localparam int DIGIT = 41;
  localparam int NDIG  = 4;
  localparam int PW    = DIGIT + M - 1;  // 203-bit digit product
  localparam int VW    = DIGIT + M;      // 204-bit pre-reduction value

  // f(x) = x^163 + x^7 + x^6 + x^3 + 1, so x^163 folds onto these taps
  localparam int RED_TAPS [4] = '{7, 6, 3, 0};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Single fold of a 204-bit value: the 41 high bits shifted by at most 7
  // stay below bit 48, so nothing re-enters the upper range.
  function automatic logic [M-1:0] red204(input logic [VW-1:0] v);
    logic [DIGIT-1:0] h;
    logic [M-1:0]     r;
    h = v[VW-1:M];
    r = v[M-1:0];
    for (int t = 0; t < 4; t++) begin
      r = r ^ ({{(M-DIGIT){1'b0}}, h} << RED_TAPS[t]);
    end
    return r;
  endfunction

endpackage

// File: rtl/multiplier_41x163.sv
// Combinational carry-less 41x163 polynomial product (203 bits).
module multiplier_41x163
  import gf163_pkg::*;
(
  input  logic [DIGIT-1:0] digit_i,
  input  logic [M-1:0]     b_i,
  output logic [PW-1:0]    p_o
);

  // XOR of b shifted by every set bit position of the digit
  always_comb begin
    p_o = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (digit_i[i]) p_o = p_o ^ ({{(DIGIT-1){1'b0}}, b_i} << i);
    end
  end

endmodule

// File: rtl/gf163_digit_mult_ctrl.sv
// GF(2^163) multiplier: four MSD-first Horner steps over one 41x163
// digit multiplier, with the modular fold applied every step.
module gf163_digit_mult_ctrl
  import gf163_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c
);

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [M-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [M-1:0]   c_q, c_d;
  logic           done_q, done_d;

  logic [DIGIT-1:0] digit;
  logic [PW-1:0]    p;
  logic [VW-1:0]    v;
  logic [M-1:0]     r;

  // Digit select; the top digit has only 40 real bits, zero-extended
  always_comb begin
    digit = '0;
    case (cnt_q)
      2'd0: digit = a_q[0*DIGIT +: DIGIT];
      2'd1: digit = a_q[1*DIGIT +: DIGIT];
      2'd2: digit = a_q[2*DIGIT +: DIGIT];
      default: digit = {1'b0, a_q[M-1:3*DIGIT]};
    endcase
  end

  multiplier_41x163 u_mul (
    .digit_i (digit),
    .b_i     (b_q),
    .p_o     (p)
  );

  assign v = {acc_q, {DIGIT{1'b0}}} ^ {1'b0, p};
  assign r = red204(v);

  // Next-state: accept in IDLE, one Horner step per RUN cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = 2'd3;
          state_d = ST_RUN;
        end
      end
      default: begin
        acc_d = r;
        if (cnt_q == 2'd0) begin
          c_d     = r;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    endcase
  end

  // State registers; reset abandons any operation and clears the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign c    = c_q;

endmodule
